sample_collector: RTL

- Bus master that sweeps the per-pin sample registers of the pin controllers on the shared addr/data bus at a programmable period.
- Packs one bit per pin into a 16-bit sample word and pushes it into an internal first-word-fall-through FIFO.
- Sits directly downstream of the pin controllers in input-stream mode; the host interface drains the FIFO.

---
 rtl/sample_collector.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sample_collector.sv
// sample_collector
//   Bus master that sweeps the sample register of each pin controller on the
//   shared addr/data bus at a programmable period. It packs one bit per pin
//   into a 16-bit word and pushes the word into an internal
//   first-word-fall-through FIFO that the host interface drains.
//
//   Optional feature macro: SAMPLE_COLLECTOR_SEQNUM_EN
//     When defined, each sweep pushes a 16-bit sweep sequence number followed
//     by the sample word, and PUSH takes two cycles.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start, stop       single-cycle control pulses
//   pin_mask          per-pin enable for each sweep (sampled live)
//   sample_period     cycles between sweep starts (sampled at each reload)
//   clear_overflow    clears the sticky overflow flag
//   bus_addr, bus_rd  bus master address and read strobe (registered)
//   bus_data_in       bus read data; bit 0 is the pin sample
//   fifo_rd           pop request
//   fifo_dout         head FIFO entry, valid while !fifo_empty
//   fifo_empty/full   FIFO status
//   fifo_count        number of entries held
//   overflow          sticky, set when a push is dropped
//   busy              high in every state except IDLE
//
// States
//   IDLE  | waiting for start; bus idle
//   SWEEP | one cycle per pin index, reading masked-in pins
//   PUSH  | write the sample word (and sequence number) to the FIFO
//   WAIT  | wait for the period counter to reach zero

module sample_collector #(
  parameter int NUM_PINS       = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int SAMPLE_REG_OFS = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            stop,
  input  logic [NUM_PINS-1:0]             pin_mask,
  input  logic [15:0]                     sample_period,
  input  logic                            clear_overflow,
  output logic [20:0]                     bus_addr,
  output logic                            bus_rd,
  input  logic [15:0]                     bus_data_in,
  input  logic                            fifo_rd,
  output logic [15:0]                     fifo_dout,
  output logic                            fifo_empty,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic                            busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_PINS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, PUSH, WAIT} state_t;

  state_t      state;
  logic [3:0]  pin_idx;
  logic [15:0] period_cnt;
  logic        stop_pend;
  logic [15:0] word;

  logic [15:0] mask_ext;
  logic [3:0]  next_idx;
  logic [15:0] reload_val;

  logic        pop_ok;
  logic        push_en;
  logic [15:0] push_data;
  logic        drop;
  int          free_slots;

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0] dout_hold;

  // Only bit 0 of the read data carries the pin sample.
  logic unused_bus_bits;
  assign unused_bus_bits = ^bus_data_in[15:1];

`ifdef SAMPLE_COLLECTOR_SEQNUM_EN
  logic [15:0] seq_num;
  logic        push_phase;
  logic        seq_drop;
`endif

  assign mask_ext   = 16'(pin_mask);
  assign next_idx   = pin_idx + 4'd1;
  // A zero period behaves as one, so sweeps simply run back-to-back.
  assign reload_val = (sample_period == 16'd0) ? 16'd0 : sample_period - 16'd1;

  function automatic logic [20:0] pin_addr(input logic [3:0] i);
    return {9'd0, i, 8'(SAMPLE_REG_OFS)};
  endfunction

  // FIFO write/drop decision for the PUSH state.
  always_comb begin
    pop_ok     = fifo_rd && (fifo_count != '0);
    free_slots = FIFO_DEPTH - int'(fifo_count) + int'(pop_ok);
    push_en    = 1'b0;
    push_data  = word;
    drop       = 1'b0;
    if (state == PUSH) begin
`ifdef SAMPLE_COLLECTOR_SEQNUM_EN
      if (!push_phase) begin
        push_data = seq_num;
        if (free_slots >= 2) push_en = 1'b1;
        else                 drop    = 1'b1;
      end else begin
        push_en = !seq_drop;
      end
`else
      if (free_slots >= 1) push_en = 1'b1;
      else                 drop    = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pin_idx    <= 4'd0;
      period_cnt <= 16'd0;
      stop_pend  <= 1'b0;
      word       <= 16'd0;
      bus_addr   <= 21'd0;
      bus_rd     <= 1'b0;
      busy       <= 1'b0;
`ifdef SAMPLE_COLLECTOR_SEQNUM_EN
      seq_num    <= 16'd0;
      push_phase <= 1'b0;
      seq_drop   <= 1'b0;
`endif
    end else begin
      bus_rd   <= 1'b0;
      bus_addr <= 21'd0;
      if (state != IDLE) begin
        period_cnt <= (period_cnt == 16'd0) ? 16'd0 : period_cnt - 16'd1;
        if (stop) stop_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state      <= SWEEP;
            busy       <= 1'b1;
            pin_idx    <= 4'd0;
            period_cnt <= reload_val;
            word       <= 16'd0;
            stop_pend  <= 1'b0;
            bus_rd     <= mask_ext[0];
            bus_addr   <= mask_ext[0] ? pin_addr(4'd0) : 21'd0;
`ifdef SAMPLE_COLLECTOR_SEQNUM_EN
            seq_num    <= 16'd0;
            push_phase <= 1'b0;
`endif
          end
        end

        SWEEP: begin
          // bus_rd is registered, so it marks the current pin as masked in.
          if (bus_rd) word[pin_idx] <= bus_data_in[0];
          if (pin_idx == LAST_IDX) begin
            state <= PUSH;
          end else begin
            pin_idx  <= next_idx;
            bus_rd   <= mask_ext[next_idx];
            bus_addr <= mask_ext[next_idx] ? pin_addr(next_idx) : 21'd0;
          end
        end

        PUSH: begin
`ifdef SAMPLE_COLLECTOR_SEQNUM_EN
          if (!push_phase) begin
            push_phase <= 1'b1;
            seq_drop   <= drop;
          end else begin
            push_phase <= 1'b0;
            seq_num    <= seq_num + 16'd1;
`endif
            if (stop_pend || stop) begin
              state     <= IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              state <= WAIT;
            end
`ifdef SAMPLE_COLLECTOR_SEQNUM_EN
          end
`endif
        end

        WAIT: begin
          if (stop || stop_pend) begin
            state     <= IDLE;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
          end else if (period_cnt == 16'd0) begin
            state      <= SWEEP;
            pin_idx    <= 4'd0;
            period_cnt <= reload_val;
            word       <= 16'd0;
            bus_rd     <= mask_ext[0];
            bus_addr   <= mask_ext[0] ? pin_addr(4'd0) : 21'd0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow || (start && state == IDLE)) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      dout_hold  <= 16'd0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr    <= rd_ptr + 1'b1;
        dout_hold <= mem[rd_ptr];
      end
      case ({push_en, pop_ok})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  // While empty, keep showing the entry that was popped last.
  assign fifo_dout  = fifo_empty ? dout_hold : mem[rd_ptr];

endmodule
